// File: rtl/bd_ram_access_ctrl_if.sv
// ============================================================================
// bd_ram_access_ctrl_if : requester, config-write and RAM-port bus bundle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface bd_ram_access_ctrl_if #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 2
);
    logic [NUM_REQ-1:0]    rdReq;
    logic [NUM_REQ*AW-1:0] rdAddr;
    logic [NUM_REQ-1:0]    rdGnt;
    logic [NUM_REQ-1:0]    rdDataValid;
    logic [31:0]           rdData;
    logic                  wrReq;
    logic [AW-1:0]         wrAddr;
    logic [31:0]           wrData;
    logic                  wrAck;
    logic                  ramWrEn;
    logic [AW-1:0]         ramWrAddr;
    logic [31:0]           ramWrData;
    logic                  ramRdEn;
    logic [AW-1:0]         ramRdAddr;
    logic [31:0]           ramRdData;

    modport slave (
        input  rdReq, rdAddr, wrReq, wrAddr, wrData, ramRdData,
        output rdGnt, rdDataValid, rdData, wrAck,
               ramWrEn, ramWrAddr, ramWrData, ramRdEn, ramRdAddr
    );

    modport master (
        output rdReq, rdAddr, wrReq, wrAddr, wrData, ramRdData,
        input  rdGnt, rdDataValid, rdData, wrAck,
               ramWrEn, ramWrAddr, ramWrData, ramRdEn, ramRdAddr
    );
endinterface

`default_nettype wire

// File: rtl/bd_ram_access_ctrl.sv
// ============================================================================
// bd_ram_access_ctrl : BD RAM init sweep, round-robin read arbiter, write pass
// Optional ECC error log: define BD_ECC_ERR_LOG_EN.   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module bd_ram_access_ctrl #(
    parameter int NUM_INT_BDS_WIDTH = 2,
    parameter int NUM_REQ           = 4,
    parameter int RD_LATENCY        = 2
) (
    input  wire logic clock_i,
    input  wire logic resetn_i,
`ifdef BD_ECC_ERR_LOG_EN
    input  wire logic                         ramSbErr_i,
    input  wire logic                         ramDbErr_i,
    input  wire logic                         errClr_i,
    output logic                              errValid_o,
    output logic                              errSb_o,
    output logic                              errDb_o,
    output logic [$clog2(NUM_REQ)-1:0]        errReqId_o,
    output logic [NUM_INT_BDS_WIDTH-1:0]      errAddr_o,
`endif
    input  wire logic clearReq_i,
    output logic      initDone_o,
    bd_ram_access_ctrl_if.slave bus
);

    localparam int AW  = NUM_INT_BDS_WIDTH;
    localparam int IDW = $clog2(NUM_REQ);
`ifdef BD_ECC_ERR_LOG_EN
    localparam int TAG_DEPTH = RD_LATENCY + 1;
`else
    localparam int TAG_DEPTH = RD_LATENCY;
`endif
    localparam logic [AW-1:0] C_INIT_LAST = '1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [AW-1:0]      initCnt_q, initCnt_d;
    logic [IDW-1:0]     rrPtr_q, rrPtr_d;
    logic               initDone_q;

    logic [TAG_DEPTH-1:0] tagVld_q;
    logic [IDW-1:0]       tagId_q [TAG_DEPTH];
    logic [NUM_REQ-1:0]   rdDataValid_q;
    logic [31:0]          rdData_q;

    logic               w_run;
    logic               w_init;
    logic               w_wrAck;
    logic               w_found;
    logic [IDW-1:0]     w_candId;
    logic [AW-1:0]      w_candAddr;
    logic               w_gnt;

    assign w_run   = resetn_i & (state_q == ST_RUN);
    assign w_init  = resetn_i & (state_q == ST_INIT);
    assign w_wrAck = w_run & bus.wrReq;

    // Round-robin search starting at the pointer, wrapping modulo NUM_REQ
    always_comb begin
        int             sum;
        logic [IDW-1:0] idx;
        w_found  = 1'b0;
        w_candId = '0;
        sum      = 0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(rrPtr_q) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = IDW'(sum);
            if (!w_found && bus.rdReq[idx]) begin
                w_found  = 1'b1;
                w_candId = idx;
            end
        end
    end

    assign w_candAddr = bus.rdAddr[int'(w_candId)*AW +: AW];
    // A read to the address being written this cycle waits one cycle so it sees the new data
    assign w_gnt      = w_run & w_found & ~(w_wrAck & (w_candAddr == bus.wrAddr));

    always_comb begin
        rrPtr_d = rrPtr_q;
        if (w_gnt) begin
            rrPtr_d = (w_candId == IDW'(NUM_REQ - 1)) ? '0 : w_candId + 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= ST_INIT;
            initCnt_q  <= '0;
            initDone_q <= 1'b0;
            rrPtr_q    <= '0;
        end else begin
            state_q    <= state_d;
            initCnt_q  <= initCnt_d;
            initDone_q <= (state_d == ST_RUN);
            rrPtr_q    <= rrPtr_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d   = state_q;
        initCnt_d = initCnt_q;
        case (state_q)
            ST_INIT: begin
                if (clearReq_i) begin
                    initCnt_d = '0;
                end else if (initCnt_q == C_INIT_LAST) begin
                    state_d   = ST_RUN;
                    initCnt_d = '0;
                end else begin
                    initCnt_d = initCnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (clearReq_i) begin
                    state_d   = ST_INIT;
                    initCnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_INIT;
                initCnt_d = '0;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.wrAck     = w_wrAck;
        bus.ramWrEn   = w_init | w_wrAck;
        bus.ramWrAddr = '0;
        bus.ramWrData = '0;
        if (w_init) begin
            bus.ramWrAddr = initCnt_q;
        end else if (w_wrAck) begin
            bus.ramWrAddr = bus.wrAddr;
            bus.ramWrData = bus.wrData;
        end
        bus.rdGnt     = '0;
        bus.ramRdEn   = w_gnt;
        bus.ramRdAddr = w_gnt ? w_candAddr : '0;
        if (w_gnt) begin
            bus.rdGnt[w_candId] = 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            tagVld_q      <= '0;
            for (int s = 0; s < TAG_DEPTH; s++) begin
                tagId_q[s] <= '0;
            end
            rdDataValid_q <= '0;
            rdData_q      <= '0;
        end else begin
            tagVld_q[0] <= w_gnt;
            tagId_q[0]  <= w_candId;
            for (int s = 1; s < TAG_DEPTH; s++) begin
                tagVld_q[s] <= tagVld_q[s-1];
                tagId_q[s]  <= tagId_q[s-1];
            end
            rdDataValid_q <= '0;
            if (tagVld_q[RD_LATENCY-1]) begin
                rdDataValid_q[tagId_q[RD_LATENCY-1]] <= 1'b1;
                rdData_q                             <= bus.ramRdData;
            end
        end
    end

    assign bus.rdDataValid = rdDataValid_q;
    assign bus.rdData      = rdData_q;
    assign initDone_o      = initDone_q;

`ifdef BD_ECC_ERR_LOG_EN
    logic [AW-1:0]  tagAddr_q [TAG_DEPTH];
    logic           errValid_q, errSb_q, errDb_q;
    logic [IDW-1:0] errReqId_q;
    logic [AW-1:0]  errAddr_q;

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int s = 0; s < TAG_DEPTH; s++) begin
                tagAddr_q[s] <= '0;
            end
        end else begin
            tagAddr_q[0] <= w_candAddr;
            for (int s = 1; s < TAG_DEPTH; s++) begin
                tagAddr_q[s] <= tagAddr_q[s-1];
            end
        end
    end

    // Clear first so an error landing with errClr is still captured
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            errValid_q <= 1'b0;
            errSb_q    <= 1'b0;
            errDb_q    <= 1'b0;
            errReqId_q <= '0;
            errAddr_q  <= '0;
        end else begin
            if (errClr_i) begin
                errValid_q <= 1'b0;
                errSb_q    <= 1'b0;
                errDb_q    <= 1'b0;
                errReqId_q <= '0;
                errAddr_q  <= '0;
            end
            if ((state_q == ST_RUN) && tagVld_q[RD_LATENCY] && (ramSbErr_i | ramDbErr_i)
                && (!errValid_q || errClr_i)) begin
                errValid_q <= 1'b1;
                errSb_q    <= ramSbErr_i;
                errDb_q    <= ramDbErr_i;
                errReqId_q <= tagId_q[RD_LATENCY];
                errAddr_q  <= tagAddr_q[RD_LATENCY];
            end
        end
    end

    assign errValid_o = errValid_q;
    assign errSb_o    = errSb_q;
    assign errDb_o    = errDb_q;
    assign errReqId_o = errReqId_q;
    assign errAddr_o  = errAddr_q;
`endif

endmodule

`default_nettype wire

// File: doc/bd_ram_access_ctrl.md
Name: bd_ram_access_ctrl

Overview:
- Sequences and shares the single-port-pair buffer-descriptor RAM (32-bit words, 2**NUM_INT_BDS_WIDTH entries) in the DMA controller.
- Runs a zero-initialisation sweep after reset or on request, so ECC RAM never returns spurious errors.
- Round-robin arbitrates the read port between NUM_REQ descriptor-fetch requesters and passes config writes through with collision protection.
- Tags each read so data and ECC status return to the correct requester after the fixed RAM latency.

Parameters:
- NUM_INT_BDS_WIDTH, 2, descriptor address width (AW); RAM depth = 2**AW.
- NUM_REQ, 4, number of read requesters (2..8).
- RD_LATENCY, 2, cycles from ramRdEn to valid ramRdData (2 = pipelined RAM, 1 = bypass).

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- clearReq  in  1  single-cycle pulse; re-runs the init sweep
- initDone  out  1  1 = RAM initialised, access enabled
- rdReq  in  NUM_REQ  per-requester read request; held until granted
- rdAddr  in  NUM_REQ*AW  packed read addresses; requester i at [i*AW +: AW]
- rdGnt  out  NUM_REQ  one-hot combinational grant
- rdDataValid  out  NUM_REQ  one-hot registered return strobe
- rdData  out  32  return data, broadcast to all requesters
- wrReq  in  1  config write request
- wrAddr  in  AW  config write address
- wrData  in  32  config write data
- wrAck  out  1  combinational; write accepted this cycle
- ramWrEn  out  1  RAM write enable
- ramWrAddr  out  AW  RAM write address
- ramWrData  out  32  RAM write data
- ramRdEn  out  1  RAM read enable
- ramRdAddr  out  AW  RAM read address
- ramRdData  in  32  RAM read data
- ramSbErr  in  1  RAM single-bit-corrected flag; valid RD_LATENCY+1 cycles after ramRdEn
- ramDbErr  in  1  RAM double-bit-detected flag; same timing as ramSbErr

Behaviour:
- States: INIT and RUN.
- Reset values: state=INIT, initCnt=0, RR pointer=0, initDone=0, rdDataValid=0, rdData=0, all tag pipelines cleared, all error outputs=0. Combinational outputs (rdGnt, wrAck, ram*) evaluate to 0 while resetn=0.
- INIT sweep:
  - ramWrEn=1, ramWrAddr=initCnt, ramWrData=0 every cycle; initCnt increments each cycle.
  - After the write at address 2**AW-1, move to RUN and set initDone=1 on the next edge. The sweep therefore takes exactly 2**AW cycles.
  - rdGnt=0 and wrAck=0 throughout INIT.
- clearReq:
  - In RUN: enter INIT next cycle with initCnt=0 and initDone=0. Reads already issued still drain and return normally.
  - In INIT: restart the sweep with initCnt=0.
- Writes (RUN only): wrAck=wrReq. When acked, ramWrEn=1 and ramWrAddr/ramWrData=wrAddr/wrData in the same cycle. Writes always take priority.
- Reads (RUN only):
  - Search starts at the RR pointer and wraps modulo NUM_REQ; the first requester with rdReq=1 is the candidate.
  - Collision rule: if the candidate's address equals wrAddr while wrAck=1, no read is granted this cycle. The write completes and the read wins next cycle, returning the newly written data.
  - On grant: rdGnt[i]=1, ramRdEn=1, ramRdAddr=rdAddr[i]; RR pointer becomes (i+1) mod NUM_REQ.
  - At most one grant per cycle. The pointer does not move when nothing is granted.
- Return path:
  - The tag {valid, reqId, addr} is shifted through a RD_LATENCY-deep pipeline.
  - rdDataValid[reqId] pulses for one cycle, RD_LATENCY+1 cycles after the grant (registered), with rdData=ramRdData captured from RAM cycle RD_LATENCY.
  - No backpressure: requesters must accept return data on the strobe.
- A fully pipelined stream of one read per cycle is supported.

Optional Feature:
- Macro: BD_ECC_ERR_LOG_EN.
- When defined:
  - Adds ports errValid out 1, errSb out 1, errDb out 1, errReqId out $clog2(NUM_REQ), errAddr out AW, errClr in 1.
  - The tag pipeline is extended one stage to align with ramSbErr/ramDbErr.
  - The first read whose flag is set latches errValid=1, errSb, errDb, errReqId and errAddr; later errors are ignored until errClr.
  - errClr clears the log, and an error arriving in the same cycle as errClr is latched.
  - Errors during the INIT sweep are never logged.
- When undefined: these ports and logic do not exist.

Test Plan:
- Reset release with AW=2 -> ramWrEn=1 for 4 cycles, addresses 0,1,2,3, data 0; initDone=1 on cycle 5; no rdGnt or wrAck before that.
- All 4 rdReq held high in RUN -> rdGnt sequence 0001,0010,0100,1000,0001; exactly one ramRdEn per cycle.
- Write 0xDEADBEEF to address 1, then req2 reads address 1 (grant at cycle t) -> rdDataValid=0100 at t+3 with rdData=0xDEADBEEF (RD_LATENCY=2).
- wrReq to address 3 (data 0x12345678) and rdReq[0] to address 3 in the same cycle -> wrAck=1 and rdGnt=0 that cycle; rdGnt[0] next cycle; returned data 0x12345678.
- clearReq pulsed while 2 reads are in flight -> both reads return; initDone drops; 4 zero writes; subsequent reads of any address return 0.
- BD_ECC_ERR_LOG_EN: req1 reads address 2 with ramSbErr=1 driven 3 cycles after ramRdEn -> errValid=1, errSb=1, errDb=0, errReqId=1, errAddr=2; a second error does not overwrite the log; errClr -> errValid=0.
